ufm_boot_loader: RTL and testbench
==================================

Name: ufm_boot_loader

Overview:
- Downstream consumer of the UFM serial word reader. It fetches a boot image from UFM one 32-bit word at a time through a req/ack handshake, then writes the image byte by byte into on-chip RAM.
- The image starts with a header word: magic in [31:16], payload length in words in [15:0]. The header is validated, and the payload words that follow are copied to RAM starting at RAM address 0.
- Sits between the UFM word reader and the boot RAM. Its done/error outputs gate CPU reset release.

Parameters:
- BASE_ADR, 23'h0, UFM word address of the header word.
- RAM_AW, 12, RAM byte-address width. Capacity is 2^RAM_AW bytes.
- MAGIC, 16'hB007, required header[31:16].
- TIMEOUT, 1024, maximum clk cycles to wait for ufm_ack per request.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load
- busy  out  1  high from the cycle after an accepted start until entry to DONE/ERR
- done  out  1  sticky; load completed successfully
- error  out  1  sticky; bad magic, bad length, or timeout
- count  out  16  payload words written so far
- ufm_req  out  1  word read request
- ufm_adr  out  23  word address; stable while ufm_req=1
- ufm_ack  in  1  one-cycle pulse; ufm_data valid in the same cycle
- ufm_data  in  32  word read from UFM
- ram_we  out  1  byte write strobe
- ram_adr  out  RAM_AW  byte address
- ram_dout  out  8  byte data

Behaviour:
- Reset value of all outputs is 0. The FSM goes to IDLE. Reset mid-load drops ufm_req in the next cycle, and any later ufm_ack is ignored.
- States: IDLE, HDR_REQ, CHECK, DAT_REQ, WRITE, DONE, ERR.
- IDLE: on start=1, clear done, error and count; set ufm_adr=BASE_ADR; go to HDR_REQ.
- start is ignored while busy=1. From DONE or ERR, start restarts the load.
- Handshake rules:
  - ufm_req rises on entry to a REQ state and stays high until the cycle ufm_ack=1 is sampled.
  - ufm_req is low in the cycle after ack.
  - ufm_adr does not change while ufm_req=1.
  - ufm_ack while ufm_req=0 is ignored.
- Timeout:
  - A wait counter is cleared on each REQ entry and increments every cycle in a REQ state.
  - Reaching TIMEOUT without ack moves the FSM to ERR and drops ufm_req.
- HDR_REQ: on ack, latch the header and go to CHECK.
- CHECK (1 cycle): go to ERR if any of the following holds:
  - header[31:16] != MAGIC;
  - len = header[15:0] is 0;
  - len*4 > 2^RAM_AW (compare at 18+ bits, no overflow).
  Otherwise set ufm_adr = BASE_ADR+1 and go to DAT_REQ.
- DAT_REQ: on ack, latch the word and go to WRITE.
- WRITE: 4 consecutive cycles with ram_we=1.
  - Bytes are written MSB first: [31:24], [23:16], [15:8], [7:0].
  - ram_adr = count*4 + k, for k = 0..3.
  - After the 4th byte: count += 1 and ufm_adr += 1. ufm_adr wraps modulo 2^23 with no error.
  - If count == len, go to DONE; else go to DAT_REQ.
- ram_we is 0 in all states except WRITE.
- DONE: done=1. ERR: error=1. busy=0 in both. Both hold until reset or a new start.
- Latency:
  - start to first ufm_req: 1 cycle.
  - Per payload word: ack to last byte written is 4 cycles, plus 1 cycle to the next ufm_req.
- count is frozen in ERR, so it reports the words successfully written.

Test Plan:
- Normal load:
  - Stimulus: header 0xB0070002, data 0x11223344 and 0xAABBCCDD, ack 5 cycles after each req.
  - Required: RAM bytes 0..7 = 11 22 33 44 AA BB CC DD; ufm_adr sequence 0, 1, 2; count=2; done=1, error=0, busy=0.
- Bad magic:
  - Stimulus: header 0xDEAD0004.
  - Required: error=1 one cycle after the CHECK cycle; zero RAM writes; no second ufm_req.
- Length bounds with RAM_AW=12:
  - len=1024 is accepted.
  - len=1025 sets error.
  - len=0 sets error.
- Timeout:
  - Stimulus: TIMEOUT=16; never ack the 2nd data request.
  - Required: ufm_req drops; error=1 after 16 waiting cycles; count=1.
- Reset mid-WRITE:
  - Stimulus: assert reset during the 2nd byte.
  - Required: all outputs 0 next cycle. A stray ufm_ack afterwards causes no RAM write, and a fresh start reloads correctly.
- Handshake robustness:
  - Stimulus: pulse start while busy; inject spurious ufm_ack while ufm_req=0.
  - Required: both are ignored; ufm_adr is stable during every req window.

Source files
------------

// File: rtl/ufm_boot_loader_if.sv
// UFM word-read handshake between the boot loader (master) and the UFM
// serial word reader (slave). One word per req/ack exchange.
interface ufm_boot_loader_if;
  logic        req;
  logic [22:0] adr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, adr, input ack, data);
  modport slave  (input req, adr, output ack, data);
endinterface

// File: rtl/ufm_boot_loader.sv
// Boot image loader: fetches a header word from UFM, validates magic and
// length, then copies the payload words into boot RAM one byte per cycle,
// MSB first, starting at RAM byte address 0. done/error gate CPU reset.
module ufm_boot_loader #(
  parameter logic [22:0] BASE_ADR = 23'h0,
  parameter int unsigned RAM_AW   = 12,
  parameter logic [15:0] MAGIC    = 16'hB007,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         count,
  ufm_boot_loader_if.master   ufm,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_adr,
  output logic [7:0]          ram_dout
);

  localparam int unsigned   WW    = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  // RAM capacity in bytes, wide enough that len*4 never overflows the compare
  localparam logic [32:0]   CAP   = 33'(1) << RAM_AW;

  typedef enum logic [2:0] {
    IDLE, HDR_REQ, CHECK, DAT_REQ, WRITE, DONE, ERR
  } state_t;

  state_t        st, nxt;
  logic [22:0]   adr;
  logic [31:0]   word;
  logic [15:0]   len;
  logic [WW-1:0] wcnt;
  logic [1:0]    k;
  logic [17:0]   badr;
  logic          go, bad, last_word, tmo;

  // start is only honoured when not busy; DONE/ERR accept it as a restart
  assign go        = start & ((st == IDLE) | (st == DONE) | (st == ERR));
  assign bad       = (word[31:16] != MAGIC) | (len == 16'd0) |
                     ({15'd0, len, 2'b00} > CAP);
  assign last_word = (count + 16'd1) == len;
  assign tmo       = (wcnt == WLAST);
  assign badr      = {count, k};
  assign ufm.adr   = adr;

  // state register
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  // next state and state-decoded outputs; ack only matters in REQ states
  always_comb begin
    nxt     = st;
    ufm.req = 1'b0;
    ram_we  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (st)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = HDR_REQ;
      end
      HDR_REQ: begin
        ufm.req = 1'b1;
        if (ufm.ack)  nxt = CHECK;
        else if (tmo) nxt = ERR;
      end
      CHECK: nxt = bad ? ERR : DAT_REQ;
      DAT_REQ: begin
        ufm.req = 1'b1;
        if (ufm.ack)  nxt = WRITE;
        else if (tmo) nxt = ERR;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (k == 2'd3) nxt = last_word ? DONE : DAT_REQ;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) nxt = HDR_REQ;
      end
      ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) nxt = HDR_REQ;
      end
      default: nxt = IDLE;
    endcase
  end

  // RAM byte lane: address count*4+k, big-endian byte order within the word
  always_comb begin
    ram_adr  = '0;
    ram_dout = 8'h00;
    if (st == WRITE) begin
      ram_adr = RAM_AW'(badr);
      case (k)
        2'd0:    ram_dout = word[31:24];
        2'd1:    ram_dout = word[23:16];
        2'd2:    ram_dout = word[15:8];
        default: ram_dout = word[7:0];
      endcase
    end
  end

  // datapath: UFM address, latched word/length, wait counter, byte index
  always_ff @(posedge clk) begin
    if (reset) begin
      adr   <= '0;
      word  <= '0;
      len   <= '0;
      wcnt  <= '0;
      k     <= '0;
      count <= '0;
    end else begin
      if (go) begin
        count <= '0;
        adr   <= BASE_ADR;
        wcnt  <= '0;
      end
      case (st)
        HDR_REQ, DAT_REQ: begin
          wcnt <= wcnt + 1'b1;
          if (ufm.ack) begin
            word <= ufm.data;
            k    <= '0;
            if (st == HDR_REQ) len <= ufm.data[15:0];
          end
        end
        CHECK: begin
          if (!bad) begin
            adr  <= BASE_ADR + 23'd1;
            wcnt <= '0;
          end
        end
        WRITE: begin
          k <= k + 2'd1;
          if (k == 2'd3) begin
            count <= count + 16'd1;
            adr   <= adr + 23'd1;
            wcnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_boot_loader.sv
// Bench for ufm_boot_loader: a UFM responder with random ack delay feeds
// images; a monitor rebuilds RAM contents and handshake history; each load
// is compared against the image-level expectation.
module tb_ufm_boot_loader;
  localparam int AW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, error, ram_we;
  logic [15:0]   count;
  logic [AW-1:0] ram_adr;
  logic [7:0]    ram_dout;

  ufm_boot_loader_if ufm();

  ufm_boot_loader #(.BASE_ADR(23'h0), .RAM_AW(AW), .MAGIC(16'hB007), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .count(count), .ufm(ufm), .ram_we(ram_we),
    .ram_adr(ram_adr), .ram_dout(ram_dout));

  always #5 clk = ~clk;

  // image and responder controls, written only by the stimulus block
  logic [31:0] img [0:2047];
  int load_id = 0, hang_idx = -1, dly_lo = 0, dly_hi = 0;
  bit spur = 1'b0;

  int checks = 0, passed = 0, fails = 0;

  // UFM responder: ack after a random delay, optionally never, and
  // optionally fire stray acks while no request is pending
  int nacks = 0, rsp_id = 0, wcur = 0, dcur = 0;
  initial begin
    ufm.ack = 1'b0;
    ufm.data = '0;
    forever begin
      @(negedge clk);
      if (rsp_id != load_id) begin rsp_id = load_id; nacks = 0; end
      ufm.ack = 1'b0;
      if (ufm.req) begin
        if (nacks != hang_idx && wcur >= dcur) begin
          ufm.ack = 1'b1;
          ufm.data = img[ufm.adr[10:0]];
          nacks++;
        end else wcur++;
      end else begin
        wcur = 0;
        dcur = int'($urandom_range(dly_hi, dly_lo));
        if (spur) begin ufm.ack = 1'b1; ufm.data = 32'hDEAD_BEEF; end
      end
    end
  end

  // monitor: RAM image, request addresses, window lengths, latencies
  logic [7:0]  ram [0:4095];
  logic [22:0] adrq [$];
  logic [22:0] held;
  int mon_id = 0, nwr = 0, run = 0, last_run = 0, ncyc = 0, ack_cyc = -1;
  int lat_bad = 0, adr_viol = 0;
  bit prev_req = 1'b0, ack_hdr = 1'b0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (mon_id != load_id) begin
        mon_id = load_id;
        for (int i = 0; i < 4096; i++) ram[i] = 'x;
        adrq.delete();
        nwr = 0;
        ack_cyc = -1;
      end
      if (ufm.req) begin
        if (!prev_req) begin
          adrq.push_back(ufm.adr);
          held = ufm.adr;
          run = 0;
          if (ack_cyc >= 0 && (ncyc - ack_cyc) != (ack_hdr ? 2 : 5)) lat_bad++;
        end else if (ufm.adr !== held) adr_viol++;
        run++;
        if (ufm.ack) begin ack_cyc = ncyc; ack_hdr = (ufm.adr == 23'd0); end
      end else if (prev_req) last_run = run;
      if (ram_we) begin ram[ram_adr] = ram_dout; nwr++; end
      prev_req = ufm.req;
      ncyc++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // header in img[0]; ndat random payload words filled behind it
  task automatic start_load(input string tag, input logic [31:0] hdr, input int ndat,
                            input int hang, input int lo, input int hi);
    img[0] = hdr;
    for (int i = 1; i <= ndat; i++) img[i] = $urandom;
    hang_idx = hang;
    dly_lo = lo;
    dly_hi = hi;
    load_id++;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".req_lat"}, {62'd0, busy, ufm.req}, 64'd3);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin step(); n++; end
    chk({tag, ".finished"}, {63'd0, n < bound}, 64'd1);
  endtask

  // expectation derived from the image: accept iff magic matches and the
  // payload fits in 4096 bytes; accepted images land big-endian at byte 0
  task automatic verify(input string tag);
    int len, nb, na;
    bit ok;
    len = int'(img[0][15:0]);
    ok = (img[0][31:16] == 16'hB007) && len != 0 && len * 4 <= 4096;
    chk({tag, ".done"},  {63'd0, done},  {63'd0, ok});
    chk({tag, ".error"}, {63'd0, error}, {63'd0, !ok});
    chk({tag, ".count"}, 64'(count), ok ? 64'(len) : 64'd0);
    chk({tag, ".writes"}, 64'(nwr), ok ? 64'(4 * len) : 64'd0);
    chk({tag, ".nreq"}, 64'(adrq.size()), ok ? 64'(len + 1) : 64'd1);
    if (ok) begin
      nb = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < 4; j++)
          if (ram[4 * i + j] !== 8'(img[1 + i] >> (24 - 8 * j))) nb++;
      chk({tag, ".ram_bad"}, 64'(nb), 64'd0);
      na = 0;
      for (int i = 0; i < adrq.size(); i++) if (adrq[i] != 23'(i)) na++;
      chk({tag, ".adr_seq_bad"}, 64'(na), 64'd0);
      chk({tag, ".lat_bad"}, 64'(lat_bad), 64'd0);
    end
  endtask

  initial begin
    int n, w, len;
    for (int i = 0; i < 2048; i++) img[i] = '0;
    reset = 1'b1;
    start = 1'b0;
    step(3);
    chk("reset.outputs", {busy, done, error, count, ufm.req, ufm.adr, ram_we, ram_adr, ram_dout}, 64'd0);
    reset = 1'b0;
    step();

    // directed normal load, fixed ack delay
    img[1] = 32'h11223344;
    img[2] = 32'hAABBCCDD;
    start_load("normal", 32'hB0070002, 0, -1, 5, 5);
    wait_idle("normal", 300);
    verify("normal");
    chk("normal.bytes", {ram[0], ram[1], ram[2], ram[3], ram[4], ram[5], ram[6], ram[7]},
        64'h11223344AABBCCDD);
    chk("normal.busy", {63'd0, busy}, 64'd0);

    // randomized valid loads
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(12, 1));
      start_load("rand", {16'hB007, 16'(len)}, len, -1, 0, 8);
      wait_idle("rand", 2000);
      verify("rand");
    end

    // bad magic: error exactly one cycle after CHECK, nothing written
    start_load("magic", 32'hDEAD0004, 4, -1, 2, 2);
    n = 0;
    while (nacks < 1 && n < 50) begin step(); n++; end
    chk("magic.hdr_ack", {63'd0, n < 50}, 64'd1);
    step();
    chk("magic.check_cycle", {62'd0, busy, error}, 64'd2);
    step();
    chk("magic.err_next", {62'd0, busy, error}, 64'd1);
    wait_idle("magic", 50);
    verify("magic");

    // length bounds for a 4 KiB RAM
    start_load("len1024", 32'hB0070400, 1024, -1, 0, 0);
    wait_idle("len1024", 10000);
    verify("len1024");
    start_load("len1025", 32'hB0070401, 0, -1, 0, 3);
    wait_idle("len1025", 100);
    verify("len1025");
    start_load("len0", 32'hB0070000, 0, -1, 0, 3);
    wait_idle("len0", 100);
    verify("len0");

    // timeout on the second data request
    start_load("tmo", 32'hB0070003, 3, 2, 1, 3);
    wait_idle("tmo", 500);
    chk("tmo.flags", {61'd0, done, error, ufm.req}, 64'd2);
    chk("tmo.count", 64'(count), 64'd1);
    chk("tmo.window", 64'(last_run), 64'(TO));
    chk("tmo.writes", 64'(nwr), 64'd4);

    // reset during the second byte of a write, then stray acks, then reload
    start_load("rstw", 32'hB0070002, 2, -1, 1, 4);
    n = 0;
    while (!(ram_we && ram_adr == 12'd1) && n < 200) begin step(); n++; end
    chk("rstw.reached", {63'd0, n < 200}, 64'd1);
    reset = 1'b1;
    step();
    chk("rstw.outputs", {busy, done, error, count, ufm.req, ufm.adr, ram_we, ram_adr, ram_dout}, 64'd0);
    reset = 1'b0;
    w = nwr;
    spur = 1'b1;
    step(6);
    spur = 1'b0;
    chk("rstw.stray_ack", {32'(nwr), 29'd0, busy, done, error}, {32'(w), 32'd0});
    len = int'($urandom_range(8, 2));
    start_load("reload", {16'hB007, 16'(len)}, len, -1, 0, 5);
    wait_idle("reload", 2000);
    verify("reload");

    // start while busy and stray acks between requests are both ignored
    spur = 1'b1;
    start_load("robust", 32'hB0070006, 6, -1, 2, 6);
    step(15);
    chk("robust.busy", {63'd0, busy}, 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("robust", 2000);
    spur = 1'b0;
    verify("robust");
    chk("adr_stable", 64'(adr_viol), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
